// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding unit.
// Used by fwd_bypass_unit and fwd_operand_sel.

package fwd_pkg;

    // Widest register address a tag entry can hold; narrower addresses are zero-extended.
    localparam int unsigned RD_MAX_W = 8;

    // Select code meaning "operand comes from the register file".
    localparam int unsigned SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                is_load;
    } tag_t;

    // Width of a select code covering RF plus DEPTH stages.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Resolves one source operand: youngest matching producer, readiness check and data mux.
// A hazard is flagged when the youngest match is a load whose data is not yet valid.

module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned RADDR_W          = 5,
    parameter int unsigned DEPTH            = 3,
    parameter int unsigned LOAD_READY_STAGE = 1,
    parameter int unsigned SEL_W            = 2
) (
    input  logic [DEPTH-1:0][$bits(tag_t)-1:0] tags,
    input  logic [RADDR_W-1:0]                 rs_addr,
    input  logic [XLEN-1:0]                    rf_data,
    input  logic [DEPTH*XLEN-1:0]              stage_data,
    output logic [XLEN-1:0]                    op,
    output logic [SEL_W-1:0]                   sel,
    output logic                               hazard
);

    logic [RD_MAX_W-1:0] rs_ext;
    tag_t                tag_k;
    logic                found;

    assign rs_ext = RD_MAX_W'(rs_addr);

    always_comb begin
        op     = rf_data;
        sel    = SEL_W'(SEL_RF);
        hazard = 1'b0;
        found  = 1'b0;
        tag_k  = '0;
        if (rs_addr == '0) begin
            op = '0;
        end else begin
            // Stage 0 is youngest; the first hit shadows all older producers.
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_k = tag_t'(tags[k]);
                if (!found && tag_k.valid && tag_k.we && (tag_k.rd == rs_ext)) begin
                    found  = 1'b1;
                    sel    = SEL_W'(k + 1);
                    op     = stage_data[k*XLEN +: XLEN];
                    hazard = tag_k.is_load && (k < LOAD_READY_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: tag pipeline over DEPTH stages, two operand selectors and load-use stall.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.

module fwd_bypass_unit
    import fwd_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned RADDR_W          = 5,
    parameter int unsigned DEPTH            = 3,
    parameter int unsigned LOAD_READY_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [RADDR_W-1:0]           id_rd,
    input  logic                         id_we,
    input  logic                         id_is_load,
    input  logic [RADDR_W-1:0]           rs1_addr,
    input  logic [RADDR_W-1:0]           rs2_addr,
    input  logic [XLEN-1:0]              rf_rs1_data,
    input  logic [XLEN-1:0]              rf_rs2_data,
    input  logic [DEPTH*XLEN-1:0]        stage_data,
    output logic [XLEN-1:0]              op_a,
    output logic [XLEN-1:0]              op_b,
    output logic [sel_width(DEPTH)-1:0]  sel_a,
    output logic [sel_width(DEPTH)-1:0]  sel_b,
    output logic                         stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_fwd_cnt
`endif
);

    localparam int unsigned SEL_W = sel_width(DEPTH);
    localparam int unsigned TAG_W = $bits(tag_t);

    tag_t [DEPTH-1:0]             tags_q;
    tag_t [DEPTH-1:0]             tags_d;
    logic [DEPTH-1:0][TAG_W-1:0]  tags_flat;
    tag_t                         id_tag;
    logic                         hazard_a;
    logic                         hazard_b;
    logic                         issue;

    always_comb begin
        id_tag         = '0;
        id_tag.valid   = 1'b1;
        id_tag.rd      = RD_MAX_W'(id_rd);
        id_tag.we      = id_we;
        id_tag.is_load = id_is_load;
    end

    assign stall = id_valid & (hazard_a | hazard_b);
    assign issue = id_valid & ~stall & ~flush;

    // Tag pipeline: shifts one stage per unheld cycle; a stalled or flushed ID injects a bubble.
    always_comb begin
        tags_d = tags_q;
        if (!hold) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tags_d[k] = tags_q[k-1];
            end
            tags_d[0] = issue ? id_tag : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            tags_flat[k] = tags_q[k];
        end
    end

    fwd_operand_sel #(
        .XLEN             (XLEN),
        .RADDR_W          (RADDR_W),
        .DEPTH            (DEPTH),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_sel_a (
        .tags       (tags_flat),
        .rs_addr    (rs1_addr),
        .rf_data    (rf_rs1_data),
        .stage_data (stage_data),
        .op         (op_a),
        .sel        (sel_a),
        .hazard     (hazard_a)
    );

    fwd_operand_sel #(
        .XLEN             (XLEN),
        .RADDR_W          (RADDR_W),
        .DEPTH            (DEPTH),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
    ) u_sel_b (
        .tags       (tags_flat),
        .rs_addr    (rs2_addr),
        .rf_data    (rf_rs2_data),
        .stage_data (stage_data),
        .op         (op_b),
        .sel        (sel_b),
        .hazard     (hazard_b)
    );

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic        fwd_a;
    logic        fwd_b;
    logic [1:0]  fwd_inc;

    assign fwd_a = (sel_a != SEL_W'(SEL_RF)) && !hazard_a;
    assign fwd_b = (sel_b != SEL_W'(SEL_RF)) && !hazard_b;

    always_comb begin
        fwd_inc = 2'd0;
        if (id_valid && !stall && !hold) begin
            fwd_inc = {1'b0, fwd_a} + {1'b0, fwd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && !hold) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            fwd_cnt_q <= fwd_cnt_q + {30'd0, fwd_inc};
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Bench for fwd_bypass_unit: directed vector table, then random traffic against an
// age-based model of in-flight producers.

module tb_fwd_bypass_unit;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int DEPTH   = 3;
    localparam int LRS     = 1;
    localparam int SEL_W   = 2;

    logic                    clk = 1'b0;
    logic                    reset, hold, flush, id_valid, id_we, id_is_load;
    logic [RADDR_W-1:0]      id_rd, rs1_addr, rs2_addr;
    logic [XLEN-1:0]         rf_rs1_data, rf_rs2_data;
    logic [DEPTH*XLEN-1:0]   stage_data;
    logic [XLEN-1:0]         op_a, op_b;
    logic [SEL_W-1:0]        sel_a, sel_b;
    logic                    stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]             perf_stall_cnt, perf_fwd_cnt;
`endif

    initial forever #5 clk = ~clk;

    fwd_bypass_unit #(
        .XLEN             (XLEN),
        .RADDR_W          (RADDR_W),
        .DEPTH            (DEPTH),
        .LOAD_READY_STAGE (LRS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .stage_data  (stage_data),
        .op_a        (op_a),
        .op_b        (op_b),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall       (stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs for one cycle plus the outputs expected during that cycle.
    typedef struct {
        bit                  rst, hld, fl, iv, we, ld;
        int                  rd, rs1, rs2;
        logic [DEPTH*XLEN-1:0] sd;
        logic [31:0]         ea, eb;
        int                  esa, esb;
        bit                  est, ca, cb, chk;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit rst, input bit hld, input bit fl, input bit iv,
                                input int rd, input bit we, input bit ld,
                                input int rs1, input int rs2,
                                input logic [31:0] sd0, input logic [31:0] sd1,
                                input logic [31:0] sd2,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input int esa, input int esb, input bit est,
                                input bit ca, input bit cb, input bit chk);
        vec_t v;
        v.rst = rst; v.hld = hld; v.fl = fl; v.iv = iv; v.rd = rd; v.we = we; v.ld = ld;
        v.rs1 = rs1; v.rs2 = rs2; v.sd = {sd2, sd1, sd0};
        v.ea = ea; v.eb = eb; v.esa = esa; v.esb = esb; v.est = est;
        v.ca = ca; v.cb = cb; v.chk = chk;
        vq.push_back(v);
    endfunction

    // Reference model: every issued instruction with its age (= current stage index).
    typedef struct {
        int rd;
        bit we;
        bit ld;
        int age;
    } inflight_t;

    inflight_t inf[$];

    function automatic void ref_operand(input int rs, input logic [31:0] rf,
                                        input logic [DEPTH*XLEN-1:0] sd,
                                        output logic [31:0] op, output int sel,
                                        output bit haz);
        int best = -1;
        op = rf; sel = 0; haz = 1'b0;
        if (rs == 0) begin
            op = 32'd0;
            return;
        end
        foreach (inf[i]) begin
            if (inf[i].we && inf[i].rd == rs && (best < 0 || inf[i].age < inf[best].age))
                best = i;
        end
        if (best >= 0) begin
            sel = inf[best].age + 1;
            if (inf[best].ld && inf[best].age < LRS) haz = 1'b1;
            else op = sd[inf[best].age*XLEN +: XLEN];
        end
    endfunction

    task automatic model_advance(input bit rst, input bit hld, input bit iss,
                                 input int rd, input bit we, input bit ld);
        inflight_t keep[$];
        inflight_t e;
        if (rst) begin
            inf.delete();
            return;
        end
        if (hld) return;
        foreach (inf[i]) begin
            if (inf[i].age + 1 < DEPTH) begin
                e = inf[i];
                e.age++;
                keep.push_back(e);
            end
        end
        if (iss) begin
            e.rd = rd; e.we = we; e.ld = ld; e.age = 0;
            keep.push_back(e);
        end
        inf = keep;
    endtask

    task automatic drive(input bit rst, input bit hld, input bit fl, input bit iv,
                         input int rd, input bit we, input bit ld,
                         input int rs1, input int rs2);
        reset = rst; hold = hld; flush = fl; id_valid = iv;
        id_rd = RADDR_W'(rd); id_we = we; id_is_load = ld;
        rs1_addr = RADDR_W'(rs1); rs2_addr = RADDR_W'(rs2);
    endtask

    initial begin
        logic [31:0] ea, eb;
        int          sa, sb;
        bit          ha, hb, est, iss;
        bit          r_rst, r_hld, r_fl, r_iv, r_we, r_ld;
        int          r_rd, r_rs1, r_rs2;
        logic [31:0] m_stall_cnt, m_fwd_cnt;

        rf_rs1_data = 32'h11;
        rf_rs2_data = 32'h22;
        stage_data  = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //  rst hld fl iv rd we ld rs1 rs2  sd0 sd1 sd2  ea eb sa sb st ca cb chk
        add(1, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  9, 0, 0,  5,  6, 0, 0, 0, 'h11, 'h22, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1,  5, 1, 0,  1,  2, 0, 0, 0, 'h11, 'h22, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1, 10, 0, 0,  5,  6, 'hAAAA, 'hBBBB, 'hCCCC, 'hAAAA, 'h22, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0,  0, 0, 0,  5,  6, 'h1234, 'hAAAA, 'h5678, 'hAAAA, 'h22, 2, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1,  7, 1, 1,  5,  0, 1, 2, 3, 3, 0, 3, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1, 11, 1, 0,  1,  7, 0, 0, 0, 'h11, 0, 0, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 11, 1, 0,  1,  7, 'h10, 'h20, 'h30, 'h11, 'h20, 0, 2, 0, 1, 1, 1);
        add(0, 0, 0, 1,  3, 1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1, 12, 1, 0,  3, 11, 1, 2, 0, 1, 2, 1, 2, 0, 1, 1, 1);
        add(0, 0, 0, 1,  3, 1, 0, 12,  2, 4, 5, 6, 4, 'h22, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 1,  0, 1, 0,  3, 12, 1, 2, 3, 1, 2, 1, 2, 0, 1, 1, 1);
        add(0, 1, 0, 1, 13, 1, 0,  0,  3, 'hFFFF, 'h77, 0, 0, 'h77, 0, 2, 0, 1, 1, 1);
        add(0, 1, 0, 1, 13, 1, 0,  0,  3, 'hFFFF, 'h77, 0, 0, 'h77, 0, 2, 0, 1, 1, 1);
        add(0, 1, 0, 1, 13, 1, 0,  0,  3, 'hFFFF, 'h77, 0, 0, 'h77, 0, 2, 0, 1, 1, 1);
        add(0, 0, 1, 1, 13, 1, 0,  0,  3, 'hFFFF, 'h77, 0, 0, 'h77, 0, 2, 0, 1, 1, 1);
        add(0, 0, 0, 1, 14, 1, 1, 13,  3, 0, 0, 'h99, 'h11, 'h99, 0, 3, 0, 1, 1, 1);
        add(1, 0, 0, 1, 15, 1, 0, 14,  0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
        add(0, 0, 0, 1, 15, 1, 0, 14,  0, 0, 0, 0, 'h11, 0, 0, 0, 0, 1, 1, 1);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].hld, vq[i].fl, vq[i].iv, vq[i].rd, vq[i].we, vq[i].ld,
                  vq[i].rs1, vq[i].rs2);
            stage_data = vq[i].sd;
            #1;
            if (vq[i].chk) begin
                if (vq[i].ca) check($sformatf("row%0d op_a", i), op_a, vq[i].ea);
                if (vq[i].cb) check($sformatf("row%0d op_b", i), op_b, vq[i].eb);
                check($sformatf("row%0d sel_a", i), 32'(sel_a), 32'(vq[i].esa));
                check($sformatf("row%0d sel_b", i), 32'(sel_b), 32'(vq[i].esb));
                check($sformatf("row%0d stall", i), 32'(stall), 32'(vq[i].est));
            end
`ifdef FWD_PERF_CNT_EN
            if (i == 8) check("directed perf_stall_cnt", perf_stall_cnt, 32'd1);
`endif
        end

        // Random phase starts from a clean reset.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_advance(1, 0, 0, 0, 0, 0);
        m_stall_cnt = 32'd0;
        m_fwd_cnt   = 32'd0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 99) == 0);
            r_hld = ($urandom_range(0, 9) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_iv  = ($urandom_range(0, 4) != 0);
            r_we  = ($urandom_range(0, 9) < 7);
            r_ld  = ($urandom_range(0, 9) < 3);
            r_rd  = int'($urandom_range(0, 7));
            r_rs1 = int'($urandom_range(0, 7));
            r_rs2 = int'($urandom_range(0, 7));
            drive(r_rst, r_hld, r_fl, r_iv, r_rd, r_we, r_ld, r_rs1, r_rs2);
            rf_rs1_data = $urandom();
            rf_rs2_data = $urandom();
            for (int k = 0; k < DEPTH; k++) stage_data[k*XLEN +: XLEN] = $urandom();
            #1;
            ref_operand(r_rs1, rf_rs1_data, stage_data, ea, sa, ha);
            ref_operand(r_rs2, rf_rs2_data, stage_data, eb, sb, hb);
            est = r_iv && (ha || hb);
            if (!ha) check($sformatf("cyc%0d op_a", c), op_a, ea);
            if (!hb) check($sformatf("cyc%0d op_b", c), op_b, eb);
            check($sformatf("cyc%0d sel_a", c), 32'(sel_a), 32'(sa));
            check($sformatf("cyc%0d sel_b", c), 32'(sel_b), 32'(sb));
            check($sformatf("cyc%0d stall", c), 32'(stall), 32'(est));
`ifdef FWD_PERF_CNT_EN
            check($sformatf("cyc%0d perf_stall_cnt", c), perf_stall_cnt, m_stall_cnt);
            check($sformatf("cyc%0d perf_fwd_cnt", c), perf_fwd_cnt, m_fwd_cnt);
`endif
            iss = r_iv && !est && !r_fl;
            @(posedge clk);
            model_advance(r_rst, r_hld, iss, r_rd, r_we, r_ld);
            if (r_rst) begin
                m_stall_cnt = 32'd0;
                m_fwd_cnt   = 32'd0;
            end else begin
                if (est && !r_hld) m_stall_cnt = m_stall_cnt + 32'd1;
                if (r_iv && !est && !r_hld)
                    m_fwd_cnt = m_fwd_cnt + 32'(sa != 0 && !ha) + 32'(sb != 0 && !hb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding block for the RV pipeline; supersedes the fixed 3-input forwarding mux.
- Tracks destination tags of in-flight instructions across DEPTH stages (stage 0 = EX … stage DEPTH-1 = WB).
- Selects the youngest ready producer for each of two source operands, and raises a load-use stall when the youngest producer's data is not yet available.
- Sits between ID/EX operand read and the ALU input muxes.

Parameters:
- XLEN, 32, operand/data width
- RADDR_W, 5, register address width
- DEPTH, 3, number of tracked producer stages (>=2)
- LOAD_READY_STAGE, 1, first stage index at which load data is valid (0 < value < DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- hold  in  1  external pipeline freeze; tag pipeline does not advance
- flush  in  1  squash instruction currently in ID
- id_valid  in  1  ID holds a valid instruction
- id_rd  in  RADDR_W  ID destination register
- id_we  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- rs1_addr, rs2_addr  in  RADDR_W each  source addresses of the instruction in ID
- rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data
- stage_data  in  DEPTH*XLEN  result of stage k at bits [k*XLEN +: XLEN]
- op_a, op_b  out  XLEN each  forwarded operands
- sel_a, sel_b  out  $clog2(DEPTH+1) each  0 = register file, k+1 = stage k
- stall  out  1  load-use hazard; ID must hold

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: all tag entries invalid (valid=0, rd=0, we=0, is_load=0). Consequently op_a=rf_rs1_data, op_b=rf_rs2_data, sel_a=sel_b=0, stall=0.
- Tag entry per stage: {valid, rd, we, is_load}.
- Advance: on each clk edge with hold=0, stage k <= stage k-1 for k>=1. Stage 0 <= ID tag if id_valid & !stall & !flush, else a bubble (valid=0).
  - hold=1: all entries keep their value; hold dominates flush and stall.
- Match, stage k for rsX: valid & we & (rd == rsX) & (rsX != 0).
- Priority: lowest k (youngest) match wins. Older matches are ignored even if ready.
- Ready, stage k: !is_load | (k >= LOAD_READY_STAGE).
- Per-operand result:
  - rsX == 0 → operand = 0, sel = 0.
  - No match → register-file data, sel = 0.
  - Youngest match ready → stage_data[k], sel = k+1.
  - Youngest match not ready → hazard; sel still = k+1, operand value is don't-care.
- stall = id_valid & (hazard_a | hazard_b). Combinational, zero latency.
  - While stalled, a bubble enters stage 0 each advancing cycle until the load reaches LOAD_READY_STAGE. Default parameters give exactly one stall cycle.
- Both operands matching the same stage is legal; each is resolved independently.
- WB-stage match (k = DEPTH-1) takes priority over the register file. No write-through is required in the RF.
- Outputs op_*, sel_*, stall are combinational from the registered tags and current inputs. No additional latency.
- Reset asserted mid-operation: all entries are cleared at the edge; the pending hazard disappears the next cycle.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
  - perf_stall_cnt increments every cycle with stall=1 & hold=0.
  - perf_fwd_cnt increments by the number of operands (0, 1 or 2) with sel != 0 and no hazard, when id_valid & !stall & !hold.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg: the tag-entry struct type {valid, rd, we, is_load}, the SEL_RF = 0 constant, and a function computing the sel width from DEPTH.
- One sub-module, fwd_operand_sel, instantiated twice (A and B). It performs the priority match, ready check and data mux for one operand.
- The tag pipeline, stall logic and counters stay in the top module.

Test Plan:
1. After reset, rs1=5, rs2=6, rf data 0x11/0x22 → op_a=0x11, op_b=0x22, sel=0/0, stall=0.
2. ALU write x5 issued, next cycle rs1=5, stage_data[0]=0xAAAA → op_a=0xAAAA, sel_a=1. Following cycle (producer in stage 1, stage_data[1]=0xAAAA) → sel_a=2.
3. Load to x7, then a consumer with rs2=7 → stall=1 for exactly 1 cycle. Next cycle sel_b=2, op_b=stage_data[1].
4. x3 written in stages 0 and 2 (0x1 and 0x3), rs1=3 → op_a=0x1, sel_a=1 (youngest wins).
5. Producer of x0 in stage 0 with stage_data=0xFFFF, rs1=0 → op_a=0, sel_a=0. hold=1 for 3 cycles → tags frozen, same sel each cycle.
6. flush with id_valid=1 → next cycle stage 0 is a bubble, no match. Reset mid-stall → stall=0 the next cycle. With FWD_PERF_CNT_EN, scenario 3 → perf_stall_cnt=1.
